// File: rtl/cdp1802_dma_sequencer_pkg.sv
// Shared definitions for the CDP1802 DMA/interrupt sequencer.
//   sc_e            : 1802 state-code encodings driven on SC[1:0]
//   *_DEFAULT       : default machine-cycle geometry
//   next_sc()       : cycle-end arbitration between fetch/execute, DMA-out and interrupt
package cdp1802_dma_sequencer_pkg;

  typedef enum logic [1:0] {
    SC_FETCH = 2'b00,
    SC_EXEC  = 2'b01,
    SC_DMA   = 2'b10,
    SC_INT   = 2'b11
  } sc_e;

  localparam int unsigned CYCLE_LEN_DEFAULT = 8;
  localparam int unsigned TPA_SLOT_DEFAULT  = 1;
  localparam int unsigned TPB_SLOT_DEFAULT  = 6;

  // A fetch is always followed by its execute, so requests are ignored out of S0.
  // DMA beats interrupt; an interrupt cycle cannot chain into another interrupt cycle.
  function automatic sc_e next_sc(input sc_e cur, input logic dma_req, input logic irq);
    sc_e nxt;
    nxt = SC_FETCH;
    if (cur == SC_FETCH) begin
      nxt = SC_EXEC;
    end else if (dma_req) begin
      nxt = SC_DMA;
    end else if (irq && (cur != SC_INT)) begin
      nxt = SC_INT;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/cdp1802_dma_sequencer_timer.sv
// machine_cycle_timer: 1802 machine-cycle slot counter.
//   clk, reset    : clock, synchronous active-high reset
//   ce            : 1802 clock enable; the counter advances only on ce
//   slot          : current slot 0..CYCLE_LEN-1
//   tpa, tpb      : registered, high for the whole TPA_SLOT / TPB_SLOT slot
//   cycle_end     : ce in the last slot of the machine cycle
module machine_cycle_timer
  import cdp1802_dma_sequencer_pkg::*;
#(
  parameter int unsigned CYCLE_LEN = CYCLE_LEN_DEFAULT,
  parameter int unsigned TPA_SLOT  = TPA_SLOT_DEFAULT,
  parameter int unsigned TPB_SLOT  = TPB_SLOT_DEFAULT,
  parameter int unsigned SLOT_W    = (CYCLE_LEN > 1) ? $clog2(CYCLE_LEN) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ce,
  output logic [SLOT_W-1:0] slot,
  output logic              tpa,
  output logic              tpb,
  output logic              cycle_end
);

  localparam logic [SLOT_W-1:0] LastSlot = SLOT_W'(CYCLE_LEN - 1);

  logic [SLOT_W-1:0] slot_next;

  assign slot_next = (slot == LastSlot) ? '0 : slot + SLOT_W'(1);
  assign cycle_end = ce & (slot == LastSlot);

  // tpa/tpb are decoded from the slot being entered so they line up with slot itself.
  always_ff @(posedge clk) begin
    if (reset) begin
      slot <= '0;
      tpa  <= 1'b0;
      tpb  <= 1'b0;
    end else if (ce) begin
      slot <= slot_next;
      tpa  <= (slot_next == SLOT_W'(TPA_SLOT));
      tpb  <= (slot_next == SLOT_W'(TPB_SLOT));
    end
  end

endmodule

// File: rtl/cdp1802_dma_sequencer.sv
// CPU-side responder to the CDP1861: machine-cycle timing plus arbitration between
// fetch/execute, DMA-out and interrupt cycles, and the R0 DMA pointer.
//   clk, reset          : clock, synchronous active-high reset
//   ce                  : one pulse per 1802 clock
//   dma_out_req, int_req: DMAO / INT levels from the 1861; ie from the core
//   r0_wr, r0_din, r0_q : core load of R0 and current R0
//   mem_rd, mem_addr    : RAM read strobe/address (address is R0 in DMA cycles, else 0)
//   mem_q               : RAM data, valid one clk after mem_rd
//   dma_data            : byte presented to the 1861 DataIn
//   sc, tpa, tpb        : state code and timing pulses
//   cpu_ce              : core advance pulse (S0/S1 cycle end only)
//   int_ack, dma_ack    : interrupt cycle taken / DMA byte delivered
module cdp1802_dma_sequencer
  import cdp1802_dma_sequencer_pkg::*;
#(
  parameter int unsigned CYCLE_LEN = CYCLE_LEN_DEFAULT,
  parameter int unsigned TPA_SLOT  = TPA_SLOT_DEFAULT,
  parameter int unsigned TPB_SLOT  = TPB_SLOT_DEFAULT,
  parameter int unsigned AW        = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          ce,
  input  logic          dma_out_req,
  input  logic          int_req,
  input  logic          ie,
  input  logic          r0_wr,
  input  logic [AW-1:0] r0_din,
  output logic [AW-1:0] r0_q,
  output logic          mem_rd,
  output logic [AW-1:0] mem_addr,
  input  logic [7:0]    mem_q,
  output logic [7:0]    dma_data,
  output logic [1:0]    sc,
  output logic          tpa,
  output logic          tpb,
  output logic          cpu_ce,
  output logic          int_ack,
  output logic          dma_ack
);

  localparam int unsigned SLOT_W = (CYCLE_LEN > 1) ? $clog2(CYCLE_LEN) : 1;

  logic [SLOT_W-1:0] slot;
  logic              cycle_end;
  sc_e               sc_q;
  logic              rd_pend_q;
  logic              in_dma;

  machine_cycle_timer #(
    .CYCLE_LEN (CYCLE_LEN),
    .TPA_SLOT  (TPA_SLOT),
    .TPB_SLOT  (TPB_SLOT),
    .SLOT_W    (SLOT_W)
  ) u_timer (
    .clk       (clk),
    .reset     (reset),
    .ce        (ce),
    .slot      (slot),
    .tpa       (tpa),
    .tpb       (tpb),
    .cycle_end (cycle_end)
  );

  assign in_dma = (sc_q == SC_DMA);

  always_ff @(posedge clk) begin
    if (reset) begin
      sc_q      <= SC_FETCH;
      r0_q      <= '0;
      dma_data  <= 8'h00;
      rd_pend_q <= 1'b0;
    end else begin
      rd_pend_q <= mem_rd;
      if (rd_pend_q) begin
        dma_data <= mem_q;
      end
      if (cycle_end) begin
        sc_q <= next_sc(sc_q, dma_out_req, int_req & ie);
      end
      // A core load overrides the DMA post-increment in the same clk.
      if (r0_wr) begin
        r0_q <= r0_din;
      end else if (cycle_end && in_dma) begin
        r0_q <= r0_q + AW'(1);
      end
    end
  end

  // Strobes are coincident with the ce that causes them; gated so reset forces them low.
  assign sc       = sc_q;
  assign mem_addr = in_dma ? r0_q : '0;
  assign mem_rd   = ~reset & ce & in_dma & (slot == '0);
  assign dma_ack  = ~reset & ce & in_dma & (slot == SLOT_W'(TPB_SLOT));
  assign cpu_ce   = ~reset & cycle_end & ((sc_q == SC_FETCH) | (sc_q == SC_EXEC));
  assign int_ack  = ~reset & cycle_end & (sc_q == SC_INT);

endmodule

// File: tb/tb_cdp1802_dma_sequencer.sv
module tb_cdp1802_dma_sequencer;

  logic        clk = 1'b0;
  logic        reset, ce, dma_out_req, int_req, ie, r0_wr;
  logic [15:0] r0_din, r0_q, mem_addr;
  logic        mem_rd, tpa, tpb, cpu_ce, int_ack, dma_ack;
  logic [7:0]  mem_q = 8'h00;
  logic [7:0]  dma_data;
  logic [1:0]  sc;
  logic [7:0]  ram [0:65535];

  int n_vec  = 0;
  int n_fail = 0;

  cdp1802_dma_sequencer dut (
    .clk         (clk),
    .reset       (reset),
    .ce          (ce),
    .dma_out_req (dma_out_req),
    .int_req     (int_req),
    .ie          (ie),
    .r0_wr       (r0_wr),
    .r0_din      (r0_din),
    .r0_q        (r0_q),
    .mem_rd      (mem_rd),
    .mem_addr    (mem_addr),
    .mem_q       (mem_q),
    .dma_data    (dma_data),
    .sc          (sc),
    .tpa         (tpa),
    .tpb         (tpb),
    .cpu_ce      (cpu_ce),
    .int_ack     (int_ack),
    .dma_ack     (dma_ack)
  );

  always #5 clk = ~clk;

  // Synchronous RAM: data one clk after the read strobe.
  always @(posedge clk) begin
    if (mem_rd) mem_q <= ram[mem_addr];
  end

  typedef struct {
    logic       dreq;
    logic       ireq;
    logic       ien;
    logic [5:0] exp;  // {sc, tpa, tpb, cpu_ce, int_ack}
  } vec_t;

  vec_t vecs [32];

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  initial begin
    for (int a = 0; a < 65536; a++) ram[a] = 8'(a) ^ 8'h3C;
    for (int a = 0; a < 8; a++) ram[16'h0100 + a] = 8'hA0 + 8'(a);
    ram[16'hFFFF] = 8'h5C;

    // Idle table: slot = i%8, cycles alternate S0/S1 regardless of requests.
    for (int i = 0; i < 32; i++) begin
      int s;
      s = i % 8;
      vecs[i].dreq = 1'b0;
      vecs[i].ireq = (i >= 16);
      vecs[i].ien  = (i >= 8 && i < 16);
      vecs[i].exp  = {((i / 8) % 2 == 1) ? 2'b01 : 2'b00, s == 1, s == 6, s == 7, 1'b0};
    end

    reset = 1'b1; ce = 1'b1; dma_out_req = 1'b0; int_req = 1'b0; ie = 1'b0;
    r0_wr = 1'b0; r0_din = 16'h0000;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_state", {14'h0, sc, tpa, tpb, cpu_ce, int_ack, dma_ack, mem_rd, r0_q},
        32'h0);
    chk("reset_dma_data", {24'h0, dma_data}, 32'h0);
    reset = 1'b0;

    for (int i = 0; i < 32; i++) begin
      dma_out_req = vecs[i].dreq;
      int_req     = vecs[i].ireq;
      ie          = vecs[i].ien;
      #1;
      chk($sformatf("idle_vec%0d", i), {26'h0, sc, tpa, tpb, cpu_ce, int_ack},
          {26'h0, vecs[i].exp});
      chk($sformatf("idle_memrd%0d", i), {31'h0, mem_rd}, 32'h0);
      tick(1);
    end

    // Interrupt requested during S0: S1 completes, then one S3.
    int_req = 1'b1; ie = 1'b1;
    tick(8); chk("int_s1", {30'h0, sc}, 32'h1);
    tick(7); chk("int_s1_cpu_ce", {31'h0, cpu_ce}, 32'h1);
    tick(1); chk("int_s3", {30'h0, sc}, 32'h3);
    tick(6); chk("int_s3_tpb", {31'h0, tpb}, 32'h1);
    tick(1); chk("int_ack_end", {30'h0, int_ack, cpu_ce}, 32'h2);
    int_req = 1'b0;
    tick(1); chk("int_back_s0", {30'h0, sc}, 32'h0);
    ie = 1'b0;

    // Eight-byte DMA burst from 0x0100.
    r0_wr = 1'b1; r0_din = 16'h0100;
    tick(1); r0_wr = 1'b0;
    chk("r0_load", {16'h0, r0_q}, 32'h0100);
    dma_out_req = 1'b1;
    tick(7); chk("dma_s0_ignored", {30'h0, sc}, 32'h1);
    tick(7); chk("dma_s1_cpu_ce", {31'h0, cpu_ce}, 32'h1);
    tick(1);
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("burst%0d_sc_rd_addr", k), {13'h0, sc, mem_rd, mem_addr},
          {13'h0, 2'b10, 1'b1, 16'h0100 + 16'(k)});
      tick(6);
      chk($sformatf("burst%0d_ack_data", k), {23'h0, dma_ack, dma_data},
          {23'h0, 1'b1, 8'hA0 + 8'(k)});
      tick(1);
      chk($sformatf("burst%0d_no_cpu_ce", k), {31'h0, cpu_ce}, 32'h0);
      if (k == 7) dma_out_req = 1'b0;
      tick(1);
    end
    chk("burst_end_sc_addr", {14'h0, sc, mem_addr}, 32'h0);
    chk("burst_r0", {16'h0, r0_q}, 32'h0108);

    // R0 wrap, with DMAO dropped at the start of the S2 cycle.
    r0_wr = 1'b1; r0_din = 16'hFFFF;
    tick(1); r0_wr = 1'b0;
    dma_out_req = 1'b1;
    tick(7); tick(8);
    dma_out_req = 1'b0;
    chk("wrap_sc_addr", {14'h0, sc, mem_addr}, {14'h0, 2'b10, 16'hFFFF});
    tick(6); chk("wrap_ack_data", {23'h0, dma_ack, dma_data}, {23'h0, 1'b1, 8'h5C});
    tick(1); chk("wrap_s2_completes", {30'h0, sc}, 32'h2);
    tick(1); chk("wrap_r0", {14'h0, sc, r0_q}, 32'h0);

    // DMA and INT together in S1: S2 first, then S3; r0_wr beats the increment.
    tick(8); tick(2);
    dma_out_req = 1'b1; int_req = 1'b1; ie = 1'b1;
    tick(6); chk("both_s2_first", {30'h0, sc}, 32'h2);
    dma_out_req = 1'b0;
    tick(7);
    r0_wr = 1'b1; r0_din = 16'h1234;
    chk("both_no_int_ack_in_s2", {31'h0, int_ack}, 32'h0);
    tick(1); r0_wr = 1'b0;
    chk("both_s3_after", {30'h0, sc}, 32'h3);
    chk("r0_wr_wins", {16'h0, r0_q}, 32'h1234);
    tick(7); chk("both_int_ack", {31'h0, int_ack}, 32'h1);
    int_req = 1'b0; ie = 1'b0;
    tick(1); chk("both_back_s0", {30'h0, sc}, 32'h0);

    // Reset at slot 4 of an S2 cycle.
    tick(8); dma_out_req = 1'b1;
    tick(8); chk("rst_in_s2", {14'h0, sc, mem_addr}, {14'h0, 2'b10, 16'h1234});
    tick(4); reset = 1'b1;
    tick(1);
    chk("rst_mid_outputs", {13'h0, sc, tpa, tpb, cpu_ce, int_ack, dma_ack, mem_rd, mem_addr},
        32'h0);
    chk("rst_mid_r0_data", {8'h0, r0_q, dma_data}, 32'h0);
    tick(1); chk("rst_no_ack_a", {31'h0, dma_ack}, 32'h0);
    tick(1); chk("rst_no_ack_b", {31'h0, dma_ack}, 32'h0);
    dma_out_req = 1'b0; reset = 1'b0;
    tick(1); chk("post_rst_tpa", {29'h0, sc, tpa}, 32'h1);

    // Sequencing holds while ce is low.
    ce = 1'b0;
    tick(5); chk("ce_low_hold", {29'h0, sc, tpa}, 32'h1);
    ce = 1'b1;
    tick(5); chk("ce_resume_tpb", {30'h0, tpa, tpb}, 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/cdp1802_dma_sequencer.md
Name: cdp1802_dma_sequencer

Overview:
- CPU-side responder to the CDP1861 video DMA/interrupt initiator.
- Generates 1802 machine-cycle timing (slot counter, TPA, TPB, SC state code) and arbitrates between normal fetch/execute cycles, DMA-out cycles and interrupt cycles.
- During DMA-out cycles it reads RAM at R0, presents the byte to the 1861 DataIn with SC=2 and a TPB strobe, and post-increments R0.
- Sits between the cdp1802 core (stalled via cpu_ce), the RAM read port and the cdp1861.

Parameters:
- CYCLE_LEN, 8, ce ticks per machine cycle (slots 0..CYCLE_LEN-1)
- TPA_SLOT, 1, slot in which tpa is high
- TPB_SLOT, 6, slot in which tpb is high
- AW, 16, address / R0 width

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- ce  in  1  one pulse per 1802 clock; all sequencing advances only on ce
- dma_out_req  in  1  DMAO from cdp1861, level
- int_req  in  1  INT from cdp1861, level
- ie  in  1  interrupt-enable flag from core
- r0_wr  in  1  core loads R0
- r0_din  in  AW  R0 load value
- r0_q  out  AW  current R0
- mem_rd  out  1  RAM read strobe
- mem_addr  out  AW  RAM address during DMA
- mem_q  in  8  RAM read data, valid 1 clk after mem_rd
- dma_data  out  8  byte to cdp1861 DataIn
- sc  out  2  state code: 00 fetch, 01 execute, 10 DMA, 11 interrupt
- tpa  out  1  timing pulse A
- tpb  out  1  timing pulse B
- cpu_ce  out  1  core advance pulse
- int_ack  out  1  interrupt cycle taken
- dma_ack  out  1  DMA byte delivered

Behaviour:
- Reset: slot=0, sc=00, r0_q=0, dma_data=0; tpa, tpb, cpu_ce, int_ack, dma_ack and mem_rd all 0. Reset mid-cycle aborts it with no R0 increment and no ack.
- Slot counter: increments on ce and wraps CYCLE_LEN-1 -> 0. A "cycle end" is a ce with slot==CYCLE_LEN-1.
- tpa/tpb: registered decode of slot==TPA_SLOT / slot==TPB_SLOT, high for the whole slot (one clk when ce is tied high). Generated in every cycle type.
- Next-state decision, taken at cycle end:
  - From S0: always S1; requests are ignored.
  - From S1, S2 or S3: dma_out_req -> S2.
  - Otherwise, from S1 or S2: int_req & ie -> S3.
  - Otherwise -> S0.
  - DMA has priority over interrupt. Back-to-back S2 cycles are allowed (8-byte lines).
- cpu_ce: one-clk pulse coincident with the cycle-end ce of S0 and S1 only. It never fires in S2 or S3, so the core is frozen there.
- S2 cycle:
  - mem_rd=1 for the clk of the slot-0 ce, with mem_addr=r0_q.
  - dma_data captures mem_q on the next clk and holds until the next S2 capture.
  - dma_ack pulses one clk at the TPB_SLOT ce.
  - r0_q <= r0_q+1 at cycle end, modulo 2^AW (FFFF -> 0000).
- S3 cycle: int_ack pulses one clk at cycle end. The core performs the X/P/T save and clears IE; the sequencer does not modify ie.
- r0_wr: loads r0_din on any clk. If it coincides with the S2 increment, r0_wr wins and the increment is dropped.
- mem_addr = r0_q whenever sc=10; 0 otherwise.
- dma_out_req deasserted mid-S2: the current S2 completes; the request is re-evaluated only at cycle end.
- int_req & ie and dma_out_req both high at end of S1: S2 is taken, and the interrupt is taken after the DMA burst if still pending.

Decomposition:
- Shared package: SC encodings SC_FETCH=2'b00, SC_EXEC=2'b01, SC_DMA=2'b10, SC_INT=2'b11; CYCLE_LEN/TPA_SLOT/TPB_SLOT defaults.
- One natural sub-module: machine_cycle_timer (slot counter, tpa/tpb decode, cycle_end strobe).
- Arbitration FSM and R0 datapath live in the top.

Test Plan:
- Idle, ce=1, no requests -> sc alternates 00,01 every 8 clks; cpu_ce every 8 clks; tpa at slot 1, tpb at slot 6 each cycle.
- r0_wr=0x0100, RAM[0x100..0x107]=0xA0..0xA7, dma_out_req held for 8 cycles -> eight S2 cycles after the current S1; dma_data 0xA0..0xA7 valid at each dma_ack; r0_q=0x0108; no cpu_ce in between.
- R0=0xFFFF, single S2 -> dma_data=RAM[0xFFFF], r0_q=0x0000.
- int_req=1, ie=1 during S0 -> S1 completes, then one S3 with int_ack at its end; int_req with ie=0 -> no S3.
- dma_out_req and int_req both rising in S1 -> S2 then S3; r0_wr coincident with S2 cycle end -> r0_q=r0_din.
- Reset asserted at slot 4 of S2 -> all outputs 0, r0_q=0, sc=00 the next clk; no dma_ack.
